// File: rtl/btb_sat2_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, 1-cycle lookup,
// independent resolve-stage update and a sequential invalidation engine.
module btb_sat2_predictor #(
  parameter int unsigned PC_W     = 64,
  parameter int unsigned ENTRIES  = 32,
  parameter int unsigned IDX_LSB  = 0,
  parameter logic [1:0]  CTR_INIT = 2'b10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  output logic            ready,
  input  logic            lkp_valid,
  input  logic [PC_W-1:0] lkp_pc,
  output logic            resp_valid,
  output logic            resp_hit,
  output logic            resp_taken,
  output logic [PC_W-1:0] resp_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_LSB - IDX_W;

  typedef enum logic {ST_FLUSH, ST_RUN} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] flush_idx, flush_idx_next;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [PC_W-1:0]    target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  logic [IDX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             lkp_accept, lkp_hit;
  logic             upd_we, upd_hit;
  logic [1:0]       upd_ctr, ctr_inc, ctr_dec;

  // Invalidation engine: one entry per cycle, restartable by flush or reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FLUSH;
      flush_idx <= '0;
    end else begin
      state     <= state_next;
      flush_idx <= flush_idx_next;
    end
  end

  always_comb begin
    state_next     = state;
    flush_idx_next = flush_idx;
    ready          = 1'b0;
    case (state)
      ST_FLUSH: begin
        if (flush) begin
          flush_idx_next = '0;
        end else if (flush_idx == IDX_W'(ENTRIES - 1)) begin
          state_next     = ST_RUN;
          flush_idx_next = '0;
        end else begin
          flush_idx_next = flush_idx + 1'b1;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
        if (flush) begin
          state_next     = ST_FLUSH;
          flush_idx_next = '0;
        end
      end
      default: begin
        state_next     = ST_FLUSH;
        flush_idx_next = '0;
      end
    endcase
  end

  always_comb begin
    lkp_idx    = lkp_pc[IDX_LSB +: IDX_W];
    lkp_tag    = lkp_pc[PC_W-1 -: TAG_W];
    lkp_accept = lkp_valid & ready;
    lkp_hit    = valid[lkp_idx] && (tag_mem[lkp_idx] == lkp_tag);

    upd_idx = upd_pc[IDX_LSB +: IDX_W];
    upd_tag = upd_pc[PC_W-1 -: TAG_W];
    upd_we  = upd_valid & ready & ~flush & ~reset;
    upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    upd_ctr = ctr_mem[upd_idx];
    ctr_inc = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'b01;
    ctr_dec = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (state == ST_FLUSH) begin
      valid[flush_idx] <= 1'b0;
    end else if (upd_we && !upd_hit && upd_taken) begin
      valid[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_we) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_mem[upd_idx]    <= ctr_inc;
          target_mem[upd_idx] <= upd_target;
        end else begin
          ctr_mem[upd_idx] <= ctr_dec;
        end
      end else if (upd_taken) begin
        tag_mem[upd_idx]    <= upd_tag;
        target_mem[upd_idx] <= upd_target;
        ctr_mem[upd_idx]    <= CTR_INIT;
      end
    end
  end

  // Response is captured from the pre-update array, giving read-before-write
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_taken  <= 1'b0;
      resp_target <= '0;
    end else begin
      resp_valid  <= lkp_accept;
      resp_hit    <= lkp_accept & lkp_hit;
      resp_taken  <= lkp_accept & lkp_hit & ctr_mem[lkp_idx][1];
      resp_target <= (lkp_accept && lkp_hit) ? target_mem[lkp_idx] : '0;
    end
  end

endmodule

// File: tb/tb_btb_sat2_predictor.sv
// Scoreboard bench for btb_sat2_predictor: randomized and directed traffic
// checked against an array-based reference model of the predictor.
module tb_btb_sat2_predictor;
  localparam int unsigned PC_W    = 64;
  localparam int unsigned ENTRIES = 32;

  logic            clk = 1'b0;
  logic            reset, flush, ready;
  logic            lkp_valid;
  logic [PC_W-1:0] lkp_pc;
  logic            resp_valid, resp_hit, resp_taken;
  logic [PC_W-1:0] resp_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;

  always #5 clk = ~clk;

  btb_sat2_predictor #(
    .PC_W(PC_W), .ENTRIES(ENTRIES), .IDX_LSB(0), .CTR_INIT(2'b10)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .ready(ready),
    .lkp_valid(lkp_valid), .lkp_pc(lkp_pc),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_taken(resp_taken),
    .resp_target(resp_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target)
  );

  typedef struct {
    int          due;
    bit          hit;
    bit          taken;
    logic [63:0] target;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_from = 0;
  bit   mon_en = 1'b0;

  // Reference model: one record per index, counter kept as a plain integer 0..3
  bit          m_valid  [ENTRIES];
  logic [63:0] m_tag    [ENTRIES];
  logic [63:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];

  function automatic int idx_of(input logic [63:0] pc);
    return int'(pc % ENTRIES);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] pc);
    return pc / ENTRIES;
  endfunction

  function automatic logic [63:0] pool_pc();
    logic [58:0] t;
    case ($urandom_range(0, 3))
      0: t = 59'h80;
      1: t = 59'h81;
      2: t = '1;
      default: t = '0;
    endcase
    return {t, 5'($urandom_range(0, 31))};
  endfunction

  task automatic step(input bit rst, input bit fl,
                      input bit lv, input logic [63:0] lpc,
                      input bit uv, input logic [63:0] upc,
                      input bit ut, input logic [63:0] utgt);
    bit   rdy;
    bit   hit;
    int   i;
    exp_t e;
    rdy = (cyc >= ready_from);
    checks++;
    if (ready !== rdy) begin
      errors++;
      $display("FAIL ready cyc=%0d got=%b want=%b", cyc, ready, rdy);
    end
    reset = rst; flush = fl;
    lkp_valid = lv; lkp_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    if (lv && rdy && !rst) begin
      i        = idx_of(lpc);
      e.due    = cyc + 1;
      e.hit    = m_valid[i] && (m_tag[i] == tag_of(lpc));
      e.taken  = e.hit && (m_ctr[i] >= 2);
      e.target = e.hit ? m_target[i] : 64'h0;
      q.push_back(e);
    end
    if (rst || fl) begin
      ready_from = cyc + 1 + ENTRIES;
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end else if (uv && rdy) begin
      i   = idx_of(upc);
      hit = m_valid[i] && (m_tag[i] == tag_of(upc));
      if (hit) begin
        if (ut) begin
          m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ut) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(upc);
        m_target[i] = utgt;
        m_ctr[i]    = 2;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic lookup(input logic [63:0] pc);
    step(0, 0, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic update(input logic [63:0] pc, input bit t, input logic [63:0] tgt);
    step(0, 0, 0, 0, 1, pc, t, tgt);
  endtask

  // Monitor: pops one expectation per presented response
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (resp_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected cyc=%0d hit=%b target=%h", cyc, resp_hit, resp_target);
        end else begin
          e = q.pop_front();
          if (e.due != cyc || resp_hit !== e.hit || resp_taken !== e.taken ||
              resp_target !== e.target) begin
            errors++;
            $display("FAIL resp cyc=%0d got hit=%b taken=%b target=%h want due=%0d hit=%b taken=%b target=%h",
                     cyc, resp_hit, resp_taken, resp_target, e.due, e.hit, e.taken, e.target);
          end
        end
      end else begin
        checks++;
        if (resp_hit !== 1'b0 || resp_taken !== 1'b0 || resp_target !== '0) begin
          errors++;
          $display("FAIL resp_idle cyc=%0d got hit=%b taken=%b target=%h want all zero",
                   cyc, resp_hit, resp_taken, resp_target);
        end
        if (q.size() > 0) begin
          checks++;
          if (q[0].due <= cyc) begin
            errors++;
            $display("FAIL resp_missing cyc=%0d got resp_valid=0 want response due %0d", cyc, q[0].due);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] lp, up;
    reset = 1'b1; flush = 1'b0;
    lkp_valid = 1'b0; lkp_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      m_valid[k] = 1'b0; m_tag[k] = '0; m_target[k] = '0; m_ctr[k] = 0;
    end
    @(posedge clk);
    cyc = 1;
    ready_from = 1 + ENTRIES;
    #1;
    mon_en = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 64'h1004, 0, 0, 0, 0);

    // Invalidation after reset: lookups refused until ready, then all miss
    for (int k = 0; k < ENTRIES + 3; k++) lookup(pool_pc());

    update(64'h1004, 1, 64'h2000);
    lookup(64'h1004);
    update(64'h1004, 0, 0);
    update(64'h1004, 0, 0);
    lookup(64'h1004);
    update(64'h1004, 0, 0);
    lookup(64'h1004);
    for (int k = 0; k < 3; k++) update(64'h1004, 1, 64'h2000 + 64'(k));
    lookup(64'h1004);
    update(64'h1004, 1, 64'h2100);
    lookup(64'h1004);

    update(64'h1024, 1, 64'h3000);
    lookup(64'h1004);
    lookup(64'h1024);

    update(64'h1024, 0, 0);
    step(0, 0, 1, 64'h1024, 1, 64'h1024, 1, 64'h3300);
    lookup(64'h1024);
    update(64'h1024, 0, 0);
    step(0, 0, 1, 64'h1024, 0, 0, 0, 0);

    // Flush in RUN with a same-cycle update, a restart mid-flush, and ignored updates
    step(0, 1, 1, 64'h1024, 1, 64'h2004, 1, 64'h4000);
    for (int k = 0; k < 10; k++) step(0, 0, 1, 64'h1024, 1, 64'h1024, 1, 64'h5000);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < ENTRIES + 2; k++) step(0, 0, 1, pool_pc(), 1, pool_pc(), 1, 64'h6000);
    lookup(64'h1024);
    lookup(64'h1004);

    for (int n = 0; n < 2000; n++) begin
      lp = pool_pc();
      up = ($urandom_range(0, 3) == 0) ? lp : pool_pc();
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) != 0), lp,
           ($urandom_range(0, 1) == 1), up, ($urandom_range(0, 2) != 0),
           {$urandom, $urandom});
    end

    // Mid-run reset followed by a full invalidation
    step(1, 0, 1, 64'h1004, 1, 64'h1004, 1, 64'h7000);
    for (int k = 0; k < ENTRIES + 3; k++) lookup(pool_pc());
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending got=%0d outstanding want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
